// File: rtl/ir_sense.sv
// IR proximity front end: gates emitters, settles, then alternates left/right A2D conversions.
// Averages 2**AVG_SHFT samples per side, applies hysteresis to the open flags, pulses IR_vld once per frame.
module ir_sense #(
    parameter int          SETTLE_CYC = 1024,
    parameter int          AVG_SHFT   = 2,
    parameter logic [2:0]  LFT_CHNL   = 3'd3,
    parameter logic [2:0]  RGHT_CHNL  = 3'd0,
    parameter logic [11:0] OPN_LO     = 12'h400,
    parameter logic [11:0] OPN_HI     = 12'h480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_en,
    output logic [11:0] lft_IR,
    output logic [11:0] rght_IR,
    output logic        lft_opn,
    output logic        rght_opn,
    output logic        IR_vld
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int AW = 12 + AVG_SHFT;
    localparam int CW = AVG_SHFT + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SMP_LAST    = CW'((2 ** AVG_SHFT) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CNV_L,
        WAIT_L,
        CNV_R,
        WAIT_R,
        UPDATE
    } state_t;

    state_t        state_q,      state_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [CW-1:0] smp_cnt_q,    smp_cnt_d;
    logic [AW-1:0] lft_acc_q,    lft_acc_d;
    logic [AW-1:0] rght_acc_q,   rght_acc_d;
    logic          strt_cnv_q,   strt_cnv_d;
    logic [2:0]    chnnl_q,      chnnl_d;
    logic          ir_en_q,      ir_en_d;
    logic [11:0]   lft_ir_q,     lft_ir_d;
    logic [11:0]   rght_ir_q,    rght_ir_d;
    logic          lft_opn_q,    lft_opn_d;
    logic          rght_opn_q,   rght_opn_d;
    logic          ir_vld_q,     ir_vld_d;

    logic [11:0]   lft_avg;
    logic [11:0]   rght_avg;

    assign lft_avg  = lft_acc_q[AW-1:AVG_SHFT];
    assign rght_avg = rght_acc_q[AW-1:AVG_SHFT];

    // Values inside [OPN_LO, OPN_HI] keep the previous flag.
    function automatic logic hyst(input logic [11:0] avg, input logic prev);
        logic nxt;
        nxt = prev;
        if (avg < OPN_LO)
            nxt = 1'b1;
        else if (avg > OPN_HI)
            nxt = 1'b0;
        return nxt;
    endfunction

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        lft_acc_d    = lft_acc_q;
        rght_acc_d   = rght_acc_q;
        strt_cnv_d   = 1'b0;
        chnnl_d      = chnnl_q;
        ir_en_d      = ir_en_q;
        lft_ir_d     = lft_ir_q;
        rght_ir_d    = rght_ir_q;
        lft_opn_d    = lft_opn_q;
        rght_opn_d   = rght_opn_q;
        ir_vld_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_en) begin
                    state_d      = SETTLE;
                    ir_en_d      = 1'b1;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SW'(1);
                if (settle_cnt_q == SETTLE_LAST)
                    state_d = CNV_L;
            end
            CNV_L: begin
                strt_cnv_d = 1'b1;
                chnnl_d    = LFT_CHNL;
                state_d    = WAIT_L;
            end
            WAIT_L: begin
                if (cnv_cmplt) begin
                    lft_acc_d = lft_acc_q + AW'(res);
                    state_d   = CNV_R;
                end
            end
            CNV_R: begin
                strt_cnv_d = 1'b1;
                chnnl_d    = RGHT_CHNL;
                state_d    = WAIT_R;
            end
            WAIT_R: begin
                if (cnv_cmplt) begin
                    rght_acc_d = rght_acc_q + AW'(res);
                    smp_cnt_d  = smp_cnt_q + CW'(1);
                    state_d    = (smp_cnt_q == SMP_LAST) ? UPDATE : CNV_L;
                end
            end
            UPDATE: begin
                lft_ir_d   = lft_avg;
                rght_ir_d  = rght_avg;
                lft_opn_d  = hyst(lft_avg, lft_opn_q);
                rght_opn_d = hyst(rght_avg, rght_opn_q);
                ir_vld_d   = 1'b1;
                lft_acc_d  = '0;
                rght_acc_d = '0;
                smp_cnt_d  = '0;
                // Emitters stay lit between back-to-back frames, so no re-settle.
                if (sample_en) begin
                    state_d = CNV_L;
                end else begin
                    state_d = IDLE;
                    ir_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            lft_acc_q    <= '0;
            rght_acc_q   <= '0;
            strt_cnv_q   <= 1'b0;
            chnnl_q      <= LFT_CHNL;
            ir_en_q      <= 1'b0;
            lft_ir_q     <= '0;
            rght_ir_q    <= '0;
            lft_opn_q    <= 1'b1;
            rght_opn_q   <= 1'b1;
            ir_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            lft_acc_q    <= lft_acc_d;
            rght_acc_q   <= rght_acc_d;
            strt_cnv_q   <= strt_cnv_d;
            chnnl_q      <= chnnl_d;
            ir_en_q      <= ir_en_d;
            lft_ir_q     <= lft_ir_d;
            rght_ir_q    <= rght_ir_d;
            lft_opn_q    <= lft_opn_d;
            rght_opn_q   <= rght_opn_d;
            ir_vld_q     <= ir_vld_d;
        end
    end

    assign strt_cnv = strt_cnv_q;
    assign chnnl    = chnnl_q;
    assign IR_en    = ir_en_q;
    assign lft_IR   = lft_ir_q;
    assign rght_IR  = rght_ir_q;
    assign lft_opn  = lft_opn_q;
    assign rght_opn = rght_opn_q;
    assign IR_vld   = ir_vld_q;

endmodule

// File: tb/tb_ir_sense.sv
// Bench for ir_sense: A2D model answering each strt_cnv 3 clocks later from per-side sample buffers,
// with a frame-level average/hysteresis reference model.
module tb_ir_sense;

    localparam int         SETTLE = 8;
    localparam int         AVG    = 2;
    localparam int         NS     = 4;
    localparam int         LO     = 'h400;
    localparam int         HI     = 'h480;
    localparam logic [2:0] LFT    = 3'd3;
    localparam logic [2:0] RGHT   = 3'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_en;
    logic [11:0] lft_IR;
    logic [11:0] rght_IR;
    logic        lft_opn;
    logic        rght_opn;
    logic        IR_vld;

    always #5 clk = ~clk;

    ir_sense #(
        .SETTLE_CYC (SETTLE),
        .AVG_SHFT   (AVG),
        .LFT_CHNL   (LFT),
        .RGHT_CHNL  (RGHT),
        .OPN_LO     (12'h400),
        .OPN_HI     (12'h480)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .IR_en     (IR_en),
        .lft_IR    (lft_IR),
        .rght_IR   (rght_IR),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .IR_vld    (IR_vld)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [11:0] lbuf [0:511];
    logic [11:0] rbuf [0:511];
    int lwr = 0, rwr = 0, lrd = 0, rrd = 0;
    logic [2:0] chq [$];
    int chnl_err = 0;
    int spur_req = 0, spur_ack = 0;

    logic [11:0] vl [0:63];
    logic [11:0] vr [0:63];
    logic        vlo [0:63];
    logic        vro [0:63];
    int vcnt = 0;

    logic [11:0] el [0:63];
    logic [11:0] er [0:63];
    logic        elo [0:63];
    logic        ero [0:63];
    int ecnt = 0;
    logic m_lopn = 1'b1, m_ropn = 1'b1;
    int fl [NS];
    int fr [NS];

    // A2D model: completes each conversion 3 clocks after strt_cnv is seen.
    initial begin : a2d
        int pend;
        logic [2:0] pch;
        pend = 0;
        pch = 3'd0;
        cnv_cmplt = 1'b0;
        res = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
            if (rst === 1'b1) begin
                pend = 0;
            end else begin
                if (spur_ack < spur_req) begin
                    cnv_cmplt = 1'b1;
                    res = 12'hFFF;
                    spur_ack++;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        if (chnnl !== pch) chnl_err++;
                        cnv_cmplt = 1'b1;
                        if (pch == LFT) begin
                            res = (lrd < lwr) ? lbuf[lrd] : 12'h000;
                            if (lrd < lwr) lrd++;
                        end else begin
                            res = (rrd < rwr) ? rbuf[rrd] : 12'h000;
                            if (rrd < rwr) rrd++;
                        end
                    end
                end
                if (strt_cnv === 1'b1) begin
                    chq.push_back(chnnl);
                    pch = chnnl;
                    pend = 3;
                end
            end
        end
    end

    initial begin : vld_mon
        forever begin
            @(posedge clk);
            #1;
            if (IR_vld === 1'b1 && vcnt < 64) begin
                vl[vcnt] = lft_IR;
                vr[vcnt] = rght_IR;
                vlo[vcnt] = lft_opn;
                vro[vcnt] = rght_opn;
                vcnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic hyst(input int a, input logic prev);
        if (a < LO) return 1'b1;
        if (a > HI) return 1'b0;
        return prev;
    endfunction

    // Loads one frame of samples and records what the frame must publish.
    task automatic queue_frame();
        int sl = 0;
        int sr = 0;
        for (int i = 0; i < NS; i++) begin
            lbuf[lwr] = 12'(fl[i]);
            lwr++;
            rbuf[rwr] = 12'(fr[i]);
            rwr++;
            sl += fl[i];
            sr += fr[i];
        end
        m_lopn = hyst(sl / NS, m_lopn);
        m_ropn = hyst(sr / NS, m_ropn);
        el[ecnt] = 12'(sl / NS);
        er[ecnt] = 12'(sr / NS);
        elo[ecnt] = m_lopn;
        ero[ecnt] = m_ropn;
        ecnt++;
    endtask

    task automatic start_frame(output int lat, output bit ok);
        int n;
        ok = 1'b0;
        lat = 0;
        sample_en = 1'b1;
        n = 0;
        while (IR_en !== 1'b1 && n < 20) begin
            @(posedge clk); #2; n++;
        end
        if (IR_en === 1'b1) begin
            n = 0;
            while (strt_cnv !== 1'b1 && n < 4 * SETTLE + 20) begin
                @(posedge clk); #2; n++;
            end
            lat = n;
            ok = (strt_cnv === 1'b1);
        end
    endtask

    task automatic wait_vld(input int v0, output bit ok);
        int n = 0;
        while (vcnt == v0 && n < 600) begin
            @(posedge clk); #2; n++;
        end
        ok = (vcnt != v0);
        repeat (10) @(posedge clk);
        #2;
    endtask

    task automatic run_frames(input int n, output bit ok);
        int v0;
        int cyc;
        v0 = vcnt;
        cyc = 0;
        sample_en = 1'b1;
        while ((vcnt - v0) < n && cyc < 200 * n) begin
            @(posedge clk); #2; cyc++;
            if (IR_en === 1'b1 && (vcnt - v0) >= n - 1) sample_en = 1'b0;
        end
        sample_en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        ok = ((vcnt - v0) == n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_en = 1'b0;
        #1;
        chk_cnt++; if (IR_en !== 1'b0) $display("FAIL reset_IR_en: got %b want 0", IR_en); else pass_cnt++;
        chk_cnt++; if (strt_cnv !== 1'b0) $display("FAIL reset_strt_cnv: got %b want 0", strt_cnv); else pass_cnt++;
        chk_cnt++; if (chnnl !== LFT) $display("FAIL reset_chnnl: got %0d want %0d", chnnl, LFT); else pass_cnt++;
        chk_cnt++; if (lft_IR !== 12'h000) $display("FAIL reset_lft_IR: got %h want 000", lft_IR); else pass_cnt++;
        chk_cnt++; if (rght_IR !== 12'h000) $display("FAIL reset_rght_IR: got %h want 000", rght_IR); else pass_cnt++;
        chk_cnt++; if (lft_opn !== 1'b1) $display("FAIL reset_lft_opn: got %b want 1", lft_opn); else pass_cnt++;
        chk_cnt++; if (rght_opn !== 1'b1) $display("FAIL reset_rght_opn: got %b want 1", rght_opn); else pass_cnt++;
        chk_cnt++; if (IR_vld !== 1'b0) $display("FAIL reset_IR_vld: got %b want 0", IR_vld); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_frame();
        int v0, e0, c0, lat;
        bit ok;
        logic [2:0] want_ch;
        for (int i = 0; i < NS; i++) begin
            fl[i] = 'h900;
            fr[i] = 'h700;
        end
        v0 = vcnt; e0 = ecnt; c0 = chq.size();
        queue_frame();
        start_frame(lat, ok);
        sample_en = 1'b0;
        chk_cnt++; if (!ok || lat != SETTLE + 1) $display("FAIL frame_settle_latency: got %0d (seen=%0d) want %0d", lat, ok, SETTLE + 1); else pass_cnt++;
        wait_vld(v0, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL frame_vld_timeout: no IR_vld within budget"); else pass_cnt++;
        chk_cnt++; if (vcnt - v0 != 1) $display("FAIL frame_vld_count: got %0d want 1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (vl[v0] !== el[e0]) $display("FAIL frame_lft_IR: got %h want %h", vl[v0], el[e0]); else pass_cnt++;
        chk_cnt++; if (vr[v0] !== er[e0]) $display("FAIL frame_rght_IR: got %h want %h", vr[v0], er[e0]); else pass_cnt++;
        chk_cnt++; if (vlo[v0] !== elo[e0]) $display("FAIL frame_lft_opn: got %b want %b", vlo[v0], elo[e0]); else pass_cnt++;
        chk_cnt++; if (vro[v0] !== ero[e0]) $display("FAIL frame_rght_opn: got %b want %b", vro[v0], ero[e0]); else pass_cnt++;
        chk_cnt++; if (chq.size() - c0 != 2 * NS) $display("FAIL frame_cnv_count: got %0d want %0d", chq.size() - c0, 2 * NS); else pass_cnt++;
        for (int k = 0; k < 2 * NS && c0 + k < chq.size(); k++) begin
            want_ch = (k % 2 == 0) ? LFT : RGHT;
            chk_cnt++; if (chq[c0 + k] !== want_ch) $display("FAIL frame_chnnl_order[%0d]: got %0d want %0d", k, chq[c0 + k], want_ch); else pass_cnt++;
        end
        chk_cnt++; if (chnl_err != 0) $display("FAIL frame_chnnl_stable: got %0d changes want 0", chnl_err); else pass_cnt++;
        chk_cnt++; if (IR_en !== 1'b0) $display("FAIL frame_idle_IR_en: got %b want 0", IR_en); else pass_cnt++;
    endtask

    task automatic test_truncation();
        int v0, e0;
        bit ok;
        fl[0] = 'h100; fl[1] = 'h101; fl[2] = 'h101; fl[3] = 'h101;
        for (int i = 0; i < NS; i++) fr[i] = $urandom_range(0, 4095);
        v0 = vcnt; e0 = ecnt;
        queue_frame();
        run_frames(1, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL trunc_vld_count: got %0d want 1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (vl[v0] !== 12'h100) $display("FAIL trunc_lft_IR: got %h want 100", vl[v0]); else pass_cnt++;
        chk_cnt++; if (vr[v0] !== er[e0]) $display("FAIL trunc_rght_IR: got %h want %h", vr[v0], er[e0]); else pass_cnt++;
    endtask

    task automatic test_hysteresis();
        int v0, e0;
        bit ok;
        int avgs [6];
        logic want [6];
        avgs[0] = 'h500; avgs[1] = 'h3FF; avgs[2] = 'h400;
        avgs[3] = 'h47F; avgs[4] = 'h481; avgs[5] = 'h480;
        want[0] = 1'b0; want[1] = 1'b1; want[2] = 1'b1;
        want[3] = 1'b1; want[4] = 1'b0; want[5] = 1'b0;
        v0 = vcnt; e0 = ecnt;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NS; i++) begin
                fl[i] = avgs[f];
                fr[i] = $urandom_range(0, 4095);
            end
            queue_frame();
        end
        run_frames(6, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL hyst_vld_count: got %0d want 6", vcnt - v0); else pass_cnt++;
        for (int f = 0; f < 6; f++) begin
            chk_cnt++; if (vlo[v0 + f] !== want[f]) $display("FAIL hyst_lft_opn[%0d]: got %b want %b", f, vlo[v0 + f], want[f]); else pass_cnt++;
            chk_cnt++; if (vl[v0 + f] !== 12'(avgs[f])) $display("FAIL hyst_lft_IR[%0d]: got %h want %h", f, vl[v0 + f], 12'(avgs[f])); else pass_cnt++;
            chk_cnt++; if (vro[v0 + f] !== ero[e0 + f]) $display("FAIL hyst_rght_opn[%0d]: got %b want %b", f, vro[v0 + f], ero[e0 + f]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int v0, e0;
        bit ok;
        v0 = vcnt; e0 = ecnt;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NS; i++) begin
                fl[i] = $urandom_range('h300, 'h5FF);
                fr[i] = $urandom_range('h300, 'h5FF);
            end
            queue_frame();
        end
        run_frames(8, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL rand_vld_count: got %0d want 8", vcnt - v0); else pass_cnt++;
        for (int f = 0; f < 8; f++) begin
            chk_cnt++; if (vl[v0 + f] !== el[e0 + f] || vr[v0 + f] !== er[e0 + f]) $display("FAIL rand_avg[%0d]: got %h/%h want %h/%h", f, vl[v0 + f], vr[v0 + f], el[e0 + f], er[e0 + f]); else pass_cnt++;
            chk_cnt++; if (vlo[v0 + f] !== elo[e0 + f] || vro[v0 + f] !== ero[e0 + f]) $display("FAIL rand_opn[%0d]: got %b/%b want %b/%b", f, vlo[v0 + f], vro[v0 + f], elo[e0 + f], ero[e0 + f]); else pass_cnt++;
        end
    endtask

    task automatic test_sample_en_drop();
        int v0, e0, c0, lat, n;
        bit ok;
        v0 = vcnt; c0 = chq.size();
        spur_req++;
        repeat (4) @(posedge clk);
        #2;
        chk_cnt++; if (IR_en !== 1'b0 || chq.size() != c0 || vcnt != v0) $display("FAIL spur_idle: got IR_en=%b cnv=%0d vld=%0d want 0/0/0", IR_en, chq.size() - c0, vcnt - v0); else pass_cnt++;
        for (int i = 0; i < NS; i++) begin
            fl[i] = $urandom_range(0, 4095);
            fr[i] = $urandom_range(0, 4095);
        end
        e0 = ecnt;
        queue_frame();
        sample_en = 1'b1;
        n = 0;
        while (IR_en !== 1'b1 && n < 20) begin
            @(posedge clk); #2; n++;
        end
        spur_req++;
        n = 0;
        while (strt_cnv !== 1'b1 && n < 4 * SETTLE + 20) begin
            @(posedge clk); #2; n++;
        end
        lat = n;
        chk_cnt++; if (lat != SETTLE + 1) $display("FAIL spur_settle_latency: got %0d want %0d", lat, SETTLE + 1); else pass_cnt++;
        n = 0;
        while (chq.size() - c0 < 3 && n < 300) begin
            @(posedge clk); #2; n++;
        end
        chk_cnt++; if (chq.size() - c0 < 3) $display("FAIL drop_reach_wait_l: got %0d conversions want 3", chq.size() - c0); else pass_cnt++;
        sample_en = 1'b0;
        wait_vld(v0, ok);
        repeat (60) @(posedge clk);
        #2;
        chk_cnt++; if (vcnt - v0 != 1) $display("FAIL drop_vld_count: got %0d want 1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (vl[v0] !== el[e0] || vr[v0] !== er[e0]) $display("FAIL drop_avg: got %h/%h want %h/%h", vl[v0], vr[v0], el[e0], er[e0]); else pass_cnt++;
        chk_cnt++; if (chq.size() - c0 != 2 * NS) $display("FAIL drop_cnv_count: got %0d want %0d", chq.size() - c0, 2 * NS); else pass_cnt++;
        chk_cnt++; if (IR_en !== 1'b0) $display("FAIL drop_idle_IR_en: got %b want 0", IR_en); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int v0, e0, c0, lat, n;
        bit ok;
        for (int i = 0; i < NS; i++) begin
            lbuf[lwr] = 12'($urandom_range(0, 4095)); lwr++;
            rbuf[rwr] = 12'($urandom_range(0, 4095)); rwr++;
        end
        c0 = chq.size();
        sample_en = 1'b1;
        n = 0;
        while (chq.size() - c0 < 2 && n < 300) begin
            @(posedge clk); #2; n++;
        end
        chk_cnt++; if (chq.size() - c0 < 2) $display("FAIL rstmid_reach_wait_r: got %0d conversions want 2", chq.size() - c0); else pass_cnt++;
        @(posedge clk); #2;
        rst = 1'b1;
        sample_en = 1'b0;
        #1;
        chk_cnt++; if (IR_en !== 1'b0 || strt_cnv !== 1'b0 || IR_vld !== 1'b0) $display("FAIL rstmid_ctrl: got IR_en=%b strt=%b vld=%b want 0/0/0", IR_en, strt_cnv, IR_vld); else pass_cnt++;
        chk_cnt++; if (lft_IR !== 12'h000 || rght_IR !== 12'h000) $display("FAIL rstmid_avg: got %h/%h want 000/000", lft_IR, rght_IR); else pass_cnt++;
        chk_cnt++; if (lft_opn !== 1'b1 || rght_opn !== 1'b1) $display("FAIL rstmid_opn: got %b/%b want 1/1", lft_opn, rght_opn); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_lopn = 1'b1;
        m_ropn = 1'b1;
        @(posedge clk); #2;
        lwr = lrd;
        rwr = rrd;
        for (int i = 0; i < NS; i++) begin
            fl[i] = 'h600;
            fr[i] = 'h600;
        end
        v0 = vcnt; e0 = ecnt;
        queue_frame();
        start_frame(lat, ok);
        sample_en = 1'b0;
        chk_cnt++; if (!ok || lat != SETTLE + 1) $display("FAIL rstmid_settle_latency: got %0d (seen=%0d) want %0d", lat, ok, SETTLE + 1); else pass_cnt++;
        wait_vld(v0, ok);
        chk_cnt++; if (vcnt - v0 != 1) $display("FAIL rstmid_vld_count: got %0d want 1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (vl[v0] !== 12'h600 || vr[v0] !== 12'h600) $display("FAIL rstmid_no_residue: got %h/%h want 600/600", vl[v0], vr[v0]); else pass_cnt++;
        chk_cnt++; if (vlo[v0] !== elo[e0] || vro[v0] !== ero[e0]) $display("FAIL rstmid_opn_after: got %b/%b want %b/%b", vlo[v0], vro[v0], elo[e0], ero[e0]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_truncation();
        test_hysteresis();
        test_random();
        test_sample_en_drop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
